uart_rx_fifo: RTL and testbench

//  Serial receive front end for the core's memory-mapped I/O port (address 0).

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_fifo.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive front end.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // 100 MHz core clock, 115200 baud
    localparam int DEFAULT_CLK_PER_BIT = 868;
    localparam int DEFAULT_DEPTH       = 16;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a push at full is accepted only
// when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO.
// Bits are timed by counting clk cycles from the falling edge of the start bit.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_pop,
    input  logic       err_clr,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       overrun,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

    // Handshake: rx_valid means rx_data holds the head byte; rx_pop consumes it on the
    // clock edge and is ignored while rx_valid is low. Pushes have no backpressure.
    logic       rxd_meta, rxs;
    rx_state_t  state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] sh, sh_n;
    logic       push, set_ferr;
    logic       fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic       par_err, par_err_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            sh      <= sh_n;
`ifdef UART_RX_PARITY_EN
            par_err <= par_err_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        sh_n      = sh;
        push      = 1'b0;
        set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = CNT_HALF;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        cnt_n     = CNT_BIT;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sh_n      = {rxs, sh[7:1]};
                    cnt_n     = CNT_BIT;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == '0) begin
                    // even parity: data bits plus parity bit hold an even number of ones
                    par_err_n = ^{sh, rxs};
                    cnt_n     = CNT_BIT;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (rxs && !par_err) push = 1'b1;
                    else                 set_ferr = 1'b1;
`else
                    if (rxs) push = 1'b1;
                    else     set_ferr = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sticky flags: a new event in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (err_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (push && fifo_full && !rx_pop) overrun <= 1'b1;
            if (set_ferr) frame_err <= 1'b1;
        end
    end

    rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(sh),
        .pop      (rx_pop),
        .pop_data (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames and pops,
// compared every cycle against a queue-based model of the receiver.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int C = 8;
    localparam int D = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // posedge index (relative to the edge before the start bit is driven) that samples the stop bit:
    // 2 sync flops + 1 edge to leave IDLE + half-bit wait + one bit period per remaining bit
    localparam int PUSH_OFS = C / 2 + 3 + (FRAME_BITS - 1) * C;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_pop;
    logic       err_clr;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       overrun;
    logic       frame_err;
    logic [2:0] state_dbg;

    int         cyc = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    bit         exp_ferr = 1'b0;
    int         ev_cyc_q[$];
    bit         ev_good_q[$];
    logic [7:0] ev_byte_q[$];
    int         n_checks = 0;
    int         n_errs = 0;
    bit         chk_en = 1'b0;
    bit         rand_done = 1'b0;

    uart_rx_fifo #(
        .CLK_PER_BIT(C),
        .DEPTH      (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_pop   (rx_pop),
        .err_clr  (err_clr),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .overrun  (overrun),
        .frame_err(frame_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue bounded at D entries plus two sticky flags.
    always @(posedge clk) begin : model
        int         sz0;
        bit         pop_now;
        bit         good;
        logic [7:0] b;
        cyc = cyc + 1;
        if (rst) begin
            sz0     = exp_q.size();
            pop_now = rx_pop && (sz0 > 0);
            if (err_clr) begin
                exp_ovr  = 1'b0;
                exp_ferr = 1'b0;
            end
            if (pop_now) void'(exp_q.pop_front());
            while (ev_cyc_q.size() > 0 && ev_cyc_q[0] == cyc) begin
                void'(ev_cyc_q.pop_front());
                good = ev_good_q.pop_front();
                b    = ev_byte_q.pop_front();
                if (!good)                     exp_ferr = 1'b1;
                else if (sz0 == D && !pop_now) exp_ovr = 1'b1;
                else                           exp_q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("rx_valid", rx_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("rx_data", rx_data, exp_q[0]);
            check("overrun", overrun, exp_ovr);
            check("frame_err", frame_err, exp_ferr);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
        ev_cyc_q.push_back(cyc + PUSH_OFS);
        ev_good_q.push_back(stop_bit && !par_flip);
        ev_byte_q.push_back(d);
        rxd = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(C);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        idle(C);
`endif
        rxd = stop_bit;
        idle(C);
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        rxd     = 1'b1;
        rx_pop  = 1'b0;
        err_clr = 1'b0;
        exp_q.delete();
        ev_cyc_q.delete();
        ev_good_q.delete();
        ev_byte_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_state", state_dbg, IDLE);
        idle(2);
        rst = 1'b1;
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        bit stop_b;
        bit flip;
        rst     = 1'b1;
        rxd     = 1'b1;
        rx_pop  = 1'b0;
        err_clr = 1'b0;
        #1;
        do_reset();
        chk_en = 1'b1;

        // single good frame, then pop
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'hA5);
        pop_one();
        check("t1_empty", rx_valid, 0);

        // 2-cycle low glitch on an idle line
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(2 * C);
        check("t2_valid", rx_valid, 0);
        check("t2_state", state_dbg, IDLE);
        check("t2_frame_err", frame_err, 0);

        // five back-to-back frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("t3_overrun", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t3_pop_data", rx_data, i);
            pop_one();
        end
        check("t3_empty", rx_valid, 0);
        pulse_clr();
        check("t3_ovr_clr", overrun, 0);

        // bad stop bit
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * C);
        check("t4_frame_err", frame_err, 1);
        check("t4_valid", rx_valid, 0);
        pulse_clr();
        check("t4_ferr_clr", frame_err, 0);

        // push at full with a pop in the same cycle
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        pc = cyc + PUSH_OFS;
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                while (cyc != pc - 1) @(negedge clk);
                rx_pop = 1'b1;
                @(negedge clk);
                rx_pop = 1'b0;
            end
        join
        check("t5_overrun", overrun, 0);
        check("t5_d0", rx_data, 8'h22); pop_one();
        check("t5_d1", rx_data, 8'h33); pop_one();
        check("t5_d2", rx_data, 8'h44); pop_one();
        check("t5_d3", rx_data, 8'h77); pop_one();
        check("t5_empty", rx_valid, 0);

        // reset in the middle of the data bits
        rxd = 1'b0;
        idle(C);
        rxd = 1'b1;
        idle(2 * C + 3);
        do_reset();
        idle(2 * C);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t6_valid", rx_valid, 1);
        check("t6_data", rx_data, 8'h5A);
        pop_one();
        check("t6_empty", rx_valid, 0);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(2);
        check("t6_par_ferr", frame_err, 1);
        check("t6_par_valid", rx_valid, 0);
        pulse_clr();
`endif

        // random frames with random pops and flag clears
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    stop_b = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
                    flip = ($urandom_range(0, 7) == 0);
`else
                    flip = 1'b0;
`endif
                    send_frame(8'($urandom_range(0, 255)), stop_b, flip);
                    if (!stop_b) idle(C + $urandom_range(0, 3));
                    else         idle($urandom_range(0, 2));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rx_pop  = ($urandom_range(0, 3) == 0);
                    err_clr = ($urandom_range(0, 15) == 0);
                    @(negedge clk);
                end
                rx_pop  = 1'b0;
                err_clr = 1'b0;
            end
        join
        idle(2);
        for (int k = 0; k < D; k++) pop_one();
        check("rand_drained", rx_valid, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
